// File: rtl/cu_pkg.sv
// Shared opcodes, state encodings and A-source selects for the accumulator
// machine controller.
package cu_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_SUB    = 4'd6,
    S_INPUT  = 4'd7,
    S_JZ     = 4'd8,
    S_JPOS   = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_RAM = 2'b10;

  function automatic state_t exec_state(input logic [2:0] op);
    case (op)
      OP_LOAD:  return S_LOAD;
      OP_STORE: return S_STORE;
      OP_ADD:   return S_ADD;
      OP_SUB:   return S_SUB;
      OP_INPUT: return S_INPUT;
      OP_JZ:    return S_JZ;
      OP_JPOS:  return S_JPOS;
      default:  return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/enter_sync_edge.sv
// Synchronises the raw Enter button and turns each rising edge into a
// registered one-clock pulse, SYNC_STAGES+1 clocks after the press.
module enter_sync_edge
  import cu_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic enter,
  output logic enter_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pulse_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], enter};
      prev_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign enter_pulse = pulse_q;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute controller for the 8-bit accumulator datapath.
// Moore outputs from state, except PCload in JZ/JPOS and Aload in INPUT.
module control_unit
  import cu_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [2:0] IR75,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       enter,
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic       Sub,
  output logic       halted,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  logic   enter_pulse;

  enter_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_enter (
    .clk         (clk),
    .clear       (clear),
    .enter       (enter),
    .enter_pulse (enter_pulse)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state_q <= S_START;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_START;
    case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = exec_state(IR75);
      S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS:
                state_d = S_FETCH;
      S_INPUT:  state_d = enter_pulse ? S_FETCH : S_INPUT;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_START;
    endcase
  end

  always_comb begin
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = ASEL_ALU;
    Aload   = 1'b0;
    Sub     = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      S_DECODE: Meminst = 1'b1;
      S_LOAD: begin
        Meminst = 1'b1;
        Asel    = ASEL_RAM;
        Aload   = 1'b1;
      end
      S_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      S_ADD: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
      end
      S_SUB: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
        Sub     = 1'b1;
      end
      S_INPUT: begin
        Asel  = ASEL_IN;
        Aload = enter_pulse;
      end
      // Flags are sampled here, in the execute cycle, never earlier.
      S_JZ: begin
        Meminst = 1'b1;
        JMPmux  = 1'b1;
        PCload  = Aeq0;
      end
      S_JPOS: begin
        Meminst = 1'b1;
        JMPmux  = 1'b1;
        PCload  = Apos;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: opcode vector table plus reset, INPUT,
// HALT and a small behavioural datapath running a four-instruction program.
module tb_control_unit;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [2:0] ir_drv = 3'b000;
  logic       aeq0_drv = 1'b0, apos_drv = 1'b0;
  logic       enter = 1'b0;
  logic       use_dp = 1'b0;
  logic [2:0] IR75;
  logic       Aeq0, Apos;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, halted;
  logic [1:0] Asel;
  logic [3:0] state;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural datapath (used only for the full-program test)
  logic [7:0] ram [32];
  logic [4:0] dp_pc;
  logic [7:0] dp_ir, dp_a;
  logic [7:0] dp_in = 8'd5;
  logic [4:0] addr;

  assign addr = Meminst ? dp_ir[4:0] : dp_pc;
  assign IR75 = use_dp ? dp_ir[7:5] : ir_drv;
  assign Aeq0 = use_dp ? (dp_a == 8'd0) : aeq0_drv;
  assign Apos = use_dp ? (dp_a != 8'd0 && !dp_a[7]) : apos_drv;

  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      dp_pc <= 5'd0;
      dp_ir <= 8'd0;
      dp_a  <= 8'd0;
      for (int i = 0; i < 32; i++) ram[i] <= 8'd0;
      ram[0]  <= 8'h80;  // INPUT
      ram[1]  <= 8'h4A;  // ADD M[10]
      ram[2]  <= 8'h2B;  // STORE M[11]
      ram[3]  <= 8'hE0;  // HALT
      ram[10] <= 8'd3;
    end else if (use_dp) begin
      if (IRload) dp_ir <= ram[addr];
      if (PCload) dp_pc <= JMPmux ? dp_ir[4:0] : dp_pc + 5'd1;
      if (Aload) begin
        case (Asel)
          2'b00:   dp_a <= Sub ? dp_a - ram[addr] : dp_a + ram[addr];
          2'b01:   dp_a <= dp_in;
          2'b10:   dp_a <= ram[addr];
          default: dp_a <= dp_a;
        endcase
      end
      if (MemWr) ram[addr] <= dp_a;
    end
  end

  control_unit #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .clear(clear), .IR75(IR75), .Aeq0(Aeq0), .Apos(Apos),
    .enter(enter), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
    .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload),
    .Sub(Sub), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  // {IRload,JMPmux,PCload,Meminst,MemWr,Asel,Aload,Sub,halted}
  localparam logic [9:0] O_NONE   = 10'b0_0_0_0_0_00_0_0_0;
  localparam logic [9:0] O_FETCH  = 10'b1_0_1_0_0_00_0_0_0;
  localparam logic [9:0] O_DECODE = 10'b0_0_0_1_0_00_0_0_0;
  localparam logic [9:0] O_LOAD   = 10'b0_0_0_1_0_10_1_0_0;
  localparam logic [9:0] O_STORE  = 10'b0_0_0_1_1_00_0_0_0;
  localparam logic [9:0] O_ADD    = 10'b0_0_0_1_0_00_1_0_0;
  localparam logic [9:0] O_SUB    = 10'b0_0_0_1_0_00_1_1_0;
  localparam logic [9:0] O_JTAKE  = 10'b0_1_1_1_0_00_0_0_0;
  localparam logic [9:0] O_JSKIP  = 10'b0_1_0_1_0_00_0_0_0;
  localparam logic [9:0] O_INWAIT = 10'b0_0_0_0_0_01_0_0_0;
  localparam logic [9:0] O_INLOAD = 10'b0_0_0_0_0_01_1_0_0;
  localparam logic [9:0] O_HALT   = 10'b0_0_0_0_0_00_0_0_1;

  function automatic logic [9:0] outs();
    return {IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, halted};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    clear = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic       aeq0;
    logic       apos;
    logic [3:0] exp_state;
    logic [9:0] exp_outs;
    logic [3:0] exp_next;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{"load",    3'b000, 1'b0, 1'b0, 4'd3,  O_LOAD,  4'd1};
    vecs[1] = '{"store",   3'b001, 1'b0, 1'b0, 4'd4,  O_STORE, 4'd1};
    vecs[2] = '{"add",     3'b010, 1'b0, 1'b0, 4'd5,  O_ADD,   4'd1};
    vecs[3] = '{"sub",     3'b011, 1'b0, 1'b0, 4'd6,  O_SUB,   4'd1};
    vecs[4] = '{"jz_t",    3'b101, 1'b1, 1'b0, 4'd8,  O_JTAKE, 4'd1};
    vecs[5] = '{"jz_n",    3'b101, 1'b0, 1'b1, 4'd8,  O_JSKIP, 4'd1};
    vecs[6] = '{"jpos_t",  3'b110, 1'b0, 1'b1, 4'd9,  O_JTAKE, 4'd1};
    vecs[7] = '{"jpos_n",  3'b110, 1'b1, 1'b0, 4'd9,  O_JSKIP, 4'd1};
    vecs[8] = '{"halt",    3'b111, 1'b0, 1'b0, 4'd10, O_HALT,  4'd10};
    vecs[9] = '{"input_w", 3'b100, 1'b0, 1'b0, 4'd7,  O_INWAIT, 4'd7};

    // Table: fetch, decode, execute, following state for each opcode
    for (int i = 0; i < 10; i++) begin
      do_reset();
      check({vecs[i].name, "_start"}, state, 4'd0);
      check({vecs[i].name, "_start_o"}, outs(), O_NONE);
      ir_drv = vecs[i].op; aeq0_drv = vecs[i].aeq0; apos_drv = vecs[i].apos;
      @(negedge clk);
      check({vecs[i].name, "_fetch_s"}, state, 4'd1);
      check({vecs[i].name, "_fetch_o"}, outs(), O_FETCH);
      @(negedge clk);
      check({vecs[i].name, "_decode_s"}, state, 4'd2);
      check({vecs[i].name, "_decode_o"}, outs(), O_DECODE);
      @(negedge clk);
      check({vecs[i].name, "_exec_s"}, state, vecs[i].exp_state);
      check({vecs[i].name, "_exec_o"}, outs(), vecs[i].exp_outs);
      @(negedge clk);
      check({vecs[i].name, "_next_s"}, state, vecs[i].exp_next);
    end

    // Reset in the middle of ADD
    do_reset();
    ir_drv = 3'b010;
    repeat (3) @(negedge clk);
    check("rst_in_add", outs(), O_ADD);
    clear = 1'b0;
    #1;
    check("rst_async_s", state, 4'd0);
    check("rst_async_o", outs(), O_NONE);
    @(negedge clk);
    check("rst_held_s", state, 4'd0);
    check("rst_held_o", outs(), O_NONE);
    clear = 1'b1;
    @(negedge clk);
    check("rst_rel_fetch", state, 4'd1);

    // INPUT: press after 5 waiting clocks, pulse SYNC+1 clocks later
    do_reset();
    ir_drv = 3'b100;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("in_wait", outs(), O_INWAIT);
      check("in_wait_s", state, 4'd7);
      @(negedge clk);
    end
    enter = 1'b1;
    for (int k = 0; k < SYNC; k++) begin
      @(negedge clk);
      check("in_sync_lat", outs(), O_INWAIT);
    end
    @(negedge clk);
    check("in_pulse", outs(), O_INLOAD);
    @(negedge clk);
    check("in_exit_fetch", state, 4'd1);
    check("in_exit_o", outs(), O_FETCH);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check("in_held_noretrig", outs(), O_INWAIT);
      @(negedge clk);
    end
    check("in_held_still", state, 4'd7);
    enter = 1'b0;
    repeat (3) @(negedge clk);
    enter = 1'b1;
    begin
      bit fired = 1'b0;
      for (int k = 0; k < 10 && !fired; k++) begin
        @(negedge clk);
        if (Aload) fired = 1'b1;
      end
      check("in_new_edge", {31'd0, fired}, 32'd1);
    end
    enter = 1'b0;

    // HALT holds under enter toggling, clear releases it
    do_reset();
    ir_drv = 3'b111;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 50; k++) begin
      enter = ~enter;
      @(negedge clk);
      check("halt_hold", {state, outs()}, {4'd10, O_HALT});
    end
    clear = 1'b0;
    #1;
    check("halt_clear", {state, outs()}, {4'd0, O_NONE});
    enter = 1'b0;
    @(negedge clk);
    clear = 1'b1;

    // Full program: INPUT 5, ADD M[10]=3, STORE M[11], HALT
    use_dp = 1'b1;
    do_reset();
    begin
      bit got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (state == 4'd7) got = 1'b1;
      end
      check("prog_reach_input", {31'd0, got}, 32'd1);
    end
    repeat (2) @(negedge clk);
    enter = 1'b1;
    repeat (5) @(negedge clk);
    enter = 1'b0;
    begin
      bit got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge clk);
        if (halted) got = 1'b1;
      end
      check("prog_halted", {31'd0, got}, 32'd1);
    end
    check("prog_ram11", {24'd0, ram[11]}, 32'd8);
    check("prog_acc", {24'd0, dp_a}, 32'd8);
    check("prog_pc", {27'd0, dp_pc}, 32'd4);
    use_dp = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
